// File: rtl/mem_read_arbiter_if.sv
// rtl/mem_read_arbiter_if.sv - CPU/GPU requester and memory read-port signals for the read arbiter
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpu_read;
    logic [ADDR_W-1:0] cpu_read_addr;
    logic [DATA_W-1:0] cpu_read_data;
    logic              cpu_read_ack;
    logic              gpu_read;
    logic [ADDR_W-1:0] gpu_read_addr;
    logic [DATA_W-1:0] gpu_read_data;
    logic              gpu_read_ack;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_read_ack;
    logic              read_timeout;

    // Arbiter side.
    modport master (
        input  cpu_read, cpu_read_addr, gpu_read, gpu_read_addr, mem_read_data, mem_read_ack,
        output cpu_read_data, cpu_read_ack, gpu_read_data, gpu_read_ack,
               mem_read, mem_read_addr, read_timeout
    );

    // Requester/memory side.
    modport slave (
        output cpu_read, cpu_read_addr, gpu_read, gpu_read_addr, mem_read_data, mem_read_ack,
        input  cpu_read_data, cpu_read_ack, gpu_read_data, gpu_read_ack,
               mem_read, mem_read_addr, read_timeout
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin CPU/GPU arbiter for the single memory read port
module mem_read_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_read_arbiter_if.master  bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic             SEL_CPU  = 1'b0;
    localparam logic             SEL_GPU  = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic [DATA_W-1:0] gpu_data_q, gpu_data_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              gpu_ack_q, gpu_ack_d;
    logic              timeout_q, timeout_d;
    logic              pick;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= SEL_GPU;
            cnt_q      <= '0;
            mem_read_q <= 1'b0;
            addr_q     <= '0;
            cpu_data_q <= '0;
            gpu_data_q <= '0;
            cpu_ack_q  <= 1'b0;
            gpu_ack_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            mem_read_q <= mem_read_d;
            addr_q     <= addr_d;
            cpu_data_q <= cpu_data_d;
            gpu_data_q <= gpu_data_d;
            cpu_ack_q  <= cpu_ack_d;
            gpu_ack_q  <= gpu_ack_d;
            timeout_q  <= timeout_d;
        end
    end

    // last_q doubles as the owner of the transaction in flight.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        mem_read_d = 1'b0;
        addr_d     = addr_q;
        cpu_data_d = cpu_data_q;
        gpu_data_d = gpu_data_q;
        cpu_ack_d  = 1'b0;
        gpu_ack_d  = 1'b0;
        timeout_d  = 1'b0;
        pick       = SEL_CPU;
        rd_data    = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_read || bus.gpu_read) begin
                    pick       = (bus.cpu_read && bus.gpu_read) ? ~last_q : bus.gpu_read;
                    last_d     = pick;
                    addr_d     = pick ? bus.gpu_read_addr : bus.cpu_read_addr;
                    mem_read_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A real ack on the final watchdog cycle still wins over the timeout.
                if (bus.mem_read_ack || cnt_q == CNT_LAST) begin
                    rd_data   = bus.mem_read_ack ? bus.mem_read_data : '0;
                    timeout_d = ~bus.mem_read_ack;
                    if (last_q == SEL_GPU) begin
                        gpu_data_d = rd_data;
                        gpu_ack_d  = 1'b1;
                    end else begin
                        cpu_data_d = rd_data;
                        cpu_ack_d  = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_read      = mem_read_q;
    assign bus.mem_read_addr = addr_q;
    assign bus.cpu_read_data = cpu_data_q;
    assign bus.cpu_read_ack  = cpu_ack_q;
    assign bus.gpu_read_data = gpu_data_q;
    assign bus.gpu_read_ack  = gpu_ack_q;
    assign bus.read_timeout  = timeout_q;
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single memory read port between the CPU (opcode/register fetch) and the GPU (sprite row fetch from the draw offset).
- Sits between both requesters and the memory block: one transaction outstanding at a time, round-robin on contention.
- A watchdog completes reads that memory never acknowledges, so neither requester deadlocks.
- Writes are not arbitrated; the CPU drives the memory write port directly.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 8, memory data width.
- TIMEOUT, 64, cycles allowed in WAIT before forced completion (must be ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_read  in  1  CPU read request (level).
- cpu_read_addr  in  ADDR_W  CPU read address; held stable while cpu_read is high.
- cpu_read_data  out  DATA_W  CPU read data; valid with cpu_read_ack, then held.
- cpu_read_ack  out  1  one-cycle completion pulse to CPU.
- gpu_read  in  1  GPU read request (level).
- gpu_read_addr  in  ADDR_W  GPU read address; held stable while gpu_read is high.
- gpu_read_data  out  DATA_W  GPU read data; valid with gpu_read_ack, then held.
- gpu_read_ack  out  1  one-cycle completion pulse to GPU.
- mem_read  out  1  one-cycle read strobe to memory.
- mem_read_addr  out  ADDR_W  address to memory; held from strobe until completion.
- mem_read_data  in  DATA_W  memory data; valid when mem_read_ack is high.
- mem_read_ack  in  1  memory completion pulse.
- read_timeout  out  1  one-cycle pulse coinciding with a forced (timed-out) ack.

Behaviour:
- Reset values: state=IDLE; all acks, mem_read and read_timeout = 0; data outputs and mem_read_addr = 0; last_grant=GPU, so the CPU wins the first tie; watchdog counter = 0.
- All outputs are registered.
- IDLE:
  - Sample cpu_read and gpu_read.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch that requester's address into mem_read_addr, record grant, update last_grant, go to ISSUE.
- ISSUE:
  - mem_read=1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT:
  - mem_read=0; counter increments each cycle.
  - On mem_read_ack: register mem_read_data into the granted requester's data output; go to DONE.
  - If the counter reaches TIMEOUT-1 without an ack: load data 0 into the granted requester's data output; go to DONE with the timeout flag set.
  - An ack in the same cycle as the timeout wins: real data is used and no timeout is flagged.
- DONE:
  - Granted requester's ack=1 for one cycle; read_timeout=1 if flagged; go to IDLE.
- Latency: request sampled at cycle 0 → mem_read at cycle 1 → memory ack at cycle 1+k (k≥1) → requester ack at cycle 2+k. Minimum is 3 cycles.
- Requester rules:
  - The requester must drop its req in the cycle after its ack, or keep it high to issue a new request.
  - IDLE is reached the cycle after DONE, so a held req is treated as a fresh request there.
  - Round-robin still applies, so back-to-back contenders alternate (CPU, GPU, CPU, …).
- The ungranted requester's ack and data are untouched during another's transaction.
- A requester dropping req mid-transaction does not abort it: the ack is still pulsed and data updated.
- mem_read_ack outside WAIT, including stale acks after reset, is ignored.
- mem_read_addr stays stable from ISSUE through DONE.
- Reset mid-transaction: immediate return to IDLE with reset values; no ack is issued for the aborted read.

Test Plan:
- CPU-only read of 0x200; memory acks 1 cycle after strobe with 0xA2 → mem_read at cycle 1 with addr 0x200; cpu_read_ack at cycle 3 with cpu_read_data=0xA2; gpu_read_ack stays 0.
- CPU (0x200) and GPU (0x050) both request at cycle 0 and hold req → grants CPU, GPU, CPU, GPU in order; each ack carries the data of its own address.
- GPU reads 0x123; memory acks after 5 cycles with 0x3C → gpu_read_ack at cycle 7, gpu_read_data=0x3C; mem_read_addr stays 0x123 throughout.
- TIMEOUT=8, memory never acks a CPU read → cpu_read_ack and read_timeout pulse together; cpu_read_data=0x00; the next pending request then proceeds normally.
- Memory ack lands exactly on the timeout cycle with 0x55 → data=0x55, read_timeout stays 0.
- reset asserted during WAIT, then memory acks afterwards → no requester ack, state IDLE, all outputs 0, stale ack ignored; the next request completes normally.
